// File: rtl/sram2_initiator.sv
// Single-outstanding bridge from a valid/ready request port onto the SRAM2 bus; optional parity via SRAM2_PARITY_EN.
// Latency: bus access responds 2 cycles after acceptance, window/alignment errors respond after 1 cycle.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready.
module sram2_initiator #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter logic [31:0] WINDOW_BYTES = 32'h0000_8000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic [31:0] mem_address,
  output logic        mem_write_enable,
  output logic [35:0] mem_data_out,
  input  logic [31:0] mem_data_in,
  input  logic        mem_parity_error
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_WIN   = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;
  localparam logic [1:0] ERR_PAR   = 2'b11;

  logic [1:0]  state;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] hold_q;
  logic [1:0]  err_q;
  logic [3:0]  parity;
  logic        perr_hit;
  logic        in_window;
  logic [32:0] win_lo;
  logic [32:0] win_end;

  // 33-bit compare so a window ending at 4 GB cannot wrap.
  assign win_lo    = {1'b0, BASE_ADDR};
  assign win_end   = win_lo + {1'b0, WINDOW_BYTES};
  assign in_window = ({1'b0, req_addr} >= win_lo) && ({1'b0, req_addr} < win_end);

`ifdef SRAM2_PARITY_EN
  assign parity   = {^lat_wdata[31:24], ^lat_wdata[23:16], ^lat_wdata[15:8], ^lat_wdata[7:0]};
  assign perr_hit = mem_parity_error;
`else
  logic unused_parity_error;
  assign unused_parity_error = mem_parity_error;
  assign parity   = 4'b0000;
  assign perr_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      lat_write <= 1'b0;
      lat_addr  <= 32'h0000_0000;
      lat_wdata <= 32'h0000_0000;
      err_q     <= ERR_OK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            if (!in_window) begin
              err_q <= ERR_WIN;
              state <= ST_RESP;
            end else if (req_addr[1:0] != 2'b00) begin
              err_q <= ERR_ALIGN;
              state <= ST_RESP;
            end else begin
              err_q <= ERR_OK;
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (lat_write && perr_hit) err_q <= ERR_PAR;
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // SRAM2 read data is only valid in the second half of the ISSUE cycle.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= 32'h0000_0000;
    end else if (state == ST_ISSUE) begin
      hold_q <= mem_data_in;
    end
  end

  assign req_ready        = (state == ST_IDLE);
  assign rsp_valid        = (state == ST_RESP);
  assign rsp_err          = (state == ST_RESP) ? err_q : ERR_OK;
  assign rsp_rdata        = (state == ST_RESP && !lat_write && err_q == ERR_OK) ? hold_q : 32'h0000_0000;
  assign mem_address      = (state == ST_ISSUE) ? lat_addr : 32'h0000_0000;
  assign mem_write_enable = (state == ST_ISSUE) && lat_write;
  assign mem_data_out     = (state == ST_ISSUE) ? {parity, lat_wdata} : 36'h0_0000_0000;

endmodule

// File: tb/tb_sram2_initiator.sv
// Directed bench for sram2_initiator: vector table plus stall and mid-transfer reset sequences.
module tb_sram2_initiator;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [31:0] mem_address;
  logic        mem_write_enable;
  logic [35:0] mem_data_out;
  logic [31:0] mem_data_in = 32'hBAD0_BAD0;
  logic        mem_parity_error;
  logic [31:0] bus_val = 32'h0;

  int errors = 0;
  int checks = 0;

  sram2_initiator dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in), .mem_parity_error(mem_parity_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SRAM2 model: returns bus_val only while a read is on the bus, junk otherwise.
  always @(posedge clock) begin
    #1;
    mem_data_in = (mem_address != 32'h0 && !mem_write_enable) ? bus_val : 32'hBAD0_BAD0;
  end

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus;
    logic        perr;
    int          rc;
    logic [1:0]  err;
    logic [31:0] rdata;
    logic        we;
    logic [31:0] maddr;
    logic [35:0] dout;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #3;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    logic v1, v2, r1, r2, we1, we2;
    logic [1:0] e1, e2;
    logic [31:0] d1, d2, a1;
    logic [35:0] o1;
    v = vecs[i];
    bus_val = v.bus;
    chk($sformatf("v%0d_ready0", i), 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = v.write; req_addr = v.addr; req_wdata = v.wdata;
    step();
    req_valid = 1'b0;
    mem_parity_error = v.perr;
    v1 = rsp_valid; e1 = rsp_err; d1 = rsp_rdata; we1 = mem_write_enable;
    a1 = mem_address; o1 = mem_data_out; r1 = req_ready;
    step();
    mem_parity_error = 1'b0;
    v2 = rsp_valid; e2 = rsp_err; d2 = rsp_rdata; we2 = mem_write_enable; r2 = req_ready;
    chk($sformatf("v%0d_we1", i), 64'(we1), 64'(v.we));
    chk($sformatf("v%0d_addr1", i), 64'(a1), 64'(v.maddr));
    chk($sformatf("v%0d_dout1", i), 64'(o1), 64'(v.dout));
    chk($sformatf("v%0d_ready1", i), 64'(r1), 64'd0);
    chk($sformatf("v%0d_we2", i), 64'(we2), 64'd0);
    if (v.rc == 1) begin
      chk($sformatf("v%0d_valid1", i), 64'(v1), 64'd1);
      chk($sformatf("v%0d_err1", i), 64'(e1), 64'(v.err));
      chk($sformatf("v%0d_rdata1", i), 64'(d1), 64'(v.rdata));
      chk($sformatf("v%0d_valid2", i), 64'(v2), 64'd0);
      chk($sformatf("v%0d_ready2", i), 64'(r2), 64'd1);
    end else begin
      chk($sformatf("v%0d_valid1", i), 64'(v1), 64'd0);
      chk($sformatf("v%0d_valid2", i), 64'(v2), 64'd1);
      chk($sformatf("v%0d_err2", i), 64'(e2), 64'(v.err));
      chk($sformatf("v%0d_rdata2", i), 64'(d2), 64'(v.rdata));
      chk($sformatf("v%0d_ready2", i), 64'(r2), 64'd0);
    end
    step();
  endtask

  initial begin
`ifdef SRAM2_PARITY_EN
    vecs[0]  = '{1'b1, 32'h1000_0010, 32'hA5A5_0F01, 32'h0, 1'b0, 2, 2'b00, 32'h0, 1'b1, 32'h1000_0010, 36'h1_A5A5_0F01};
    vecs[6]  = '{1'b1, 32'h1000_0004, 32'h0000_0001, 32'h0, 1'b0, 2, 2'b00, 32'h0, 1'b1, 32'h1000_0004, 36'h1_0000_0001};
    vecs[7]  = '{1'b1, 32'h1000_0008, 32'h0000_0001, 32'h0, 1'b1, 2, 2'b11, 32'h0, 1'b1, 32'h1000_0008, 36'h1_0000_0001};
    vecs[11] = '{1'b1, 32'h1000_0100, 32'h0102_0307, 32'h0, 1'b0, 2, 2'b00, 32'h0, 1'b1, 32'h1000_0100, 36'hD_0102_0307};
`else
    vecs[0]  = '{1'b1, 32'h1000_0010, 32'hA5A5_0F01, 32'h0, 1'b0, 2, 2'b00, 32'h0, 1'b1, 32'h1000_0010, 36'h0_A5A5_0F01};
    vecs[6]  = '{1'b1, 32'h1000_0004, 32'h0000_0001, 32'h0, 1'b0, 2, 2'b00, 32'h0, 1'b1, 32'h1000_0004, 36'h0_0000_0001};
    vecs[7]  = '{1'b1, 32'h1000_0008, 32'h0000_0001, 32'h0, 1'b1, 2, 2'b00, 32'h0, 1'b1, 32'h1000_0008, 36'h0_0000_0001};
    vecs[11] = '{1'b1, 32'h1000_0100, 32'h0102_0307, 32'h0, 1'b0, 2, 2'b00, 32'h0, 1'b1, 32'h1000_0100, 36'h0_0102_0307};
`endif
    vecs[1]  = '{1'b0, 32'h1000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 2'b00, 32'hDEAD_BEEF, 1'b0, 32'h1000_0010, 36'h0};
    vecs[2]  = '{1'b0, 32'h1000_8000, 32'h0, 32'h1111_1111, 1'b0, 1, 2'b01, 32'h0, 1'b0, 32'h0, 36'h0};
    vecs[3]  = '{1'b0, 32'h0FFF_FFFC, 32'h0, 32'h1111_1111, 1'b0, 1, 2'b01, 32'h0, 1'b0, 32'h0, 36'h0};
    vecs[4]  = '{1'b0, 32'h1000_7FFC, 32'h0, 32'h1234_5678, 1'b0, 2, 2'b00, 32'h1234_5678, 1'b0, 32'h1000_7FFC, 36'h0};
    vecs[5]  = '{1'b1, 32'h1000_0002, 32'h5555_5555, 32'h0, 1'b0, 1, 2'b10, 32'h0, 1'b0, 32'h0, 36'h0};
    vecs[8]  = '{1'b0, 32'h1000_0000, 32'h0, 32'hCAFE_F00D, 1'b0, 2, 2'b00, 32'hCAFE_F00D, 1'b0, 32'h1000_0000, 36'h0};
    vecs[9]  = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 32'h0, 1'b0, 1, 2'b01, 32'h0, 1'b0, 32'h0, 36'h0};
    vecs[10] = '{1'b0, 32'h1000_7FFE, 32'h0, 32'h2222_2222, 1'b0, 1, 2'b10, 32'h0, 1'b0, 32'h0, 36'h0};
    vecs[12] = '{1'b0, 32'h1000_0040, 32'h0, 32'h0000_0000, 1'b1, 2, 2'b00, 32'h0, 1'b0, 32'h1000_0040, 36'h0};

    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    rsp_ready = 1'b1; mem_parity_error = 1'b0;
    #12;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_mem_addr", 64'(mem_address), 64'd0);
    chk("rst_mem_we", 64'(mem_write_enable), 64'd0);
    chk("rst_mem_dout", 64'(mem_data_out), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 13; i++) run_vec(i);

    // Response stall: output must hold and new requests must be ignored.
    bus_val = 32'h1111_2222;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h1000_0010; req_wdata = 32'h0;
    step();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1000_0020; req_wdata = 32'h7777_7777;
    step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_valid", k), 64'(rsp_valid), 64'd1);
      chk($sformatf("stall%0d_rdata", k), 64'(rsp_rdata), 64'h1111_2222);
      chk($sformatf("stall%0d_err", k), 64'(rsp_err), 64'd0);
      chk($sformatf("stall%0d_ready", k), 64'(req_ready), 64'd0);
      chk($sformatf("stall%0d_we", k), 64'(mem_write_enable), 64'd0);
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    chk("stall_end_valid", 64'(rsp_valid), 64'd0);
    chk("stall_end_ready", 64'(req_ready), 64'd1);
    step();
    chk("stall_no_issue", 64'(mem_write_enable), 64'd0);

    // Reset pulse during ISSUE abandons the write.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1000_0010; req_wdata = 32'h0000_0001;
    step();
    req_valid = 1'b0;
    chk("rstiss_we_before", 64'(mem_write_enable), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("rstiss_we", 64'(mem_write_enable), 64'd0);
    chk("rstiss_addr", 64'(mem_address), 64'd0);
    chk("rstiss_dout", 64'(mem_data_out), 64'd0);
    chk("rstiss_ready", 64'(req_ready), 64'd1);
    chk("rstiss_valid", 64'(rsp_valid), 64'd0);
    #2;
    reset_n = 1'b1;
    step();
    chk("rstiss_valid_c1", 64'(rsp_valid), 64'd0);
    step();
    chk("rstiss_valid_c2", 64'(rsp_valid), 64'd0);
    chk("rstiss_ready_c2", 64'(req_ready), 64'd1);

    run_vec(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram2_initiator.md
SRAM2_INITIATOR -- requirements
Module: sram2_initiator

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1000_0000, meaning first byte address of the SRAM2 window.
REQ-002 Parameter WINDOW_BYTES, default 32'h0000_8000, meaning size of the SRAM2 window in bytes (32 KBytes).
REQ-003 Port clock  input  1  meaning single system clock; all state changes on rising edge except read capture (REQ-014).
REQ-004 Port reset_n  input  1  meaning asynchronous, active-low reset.
REQ-005 Port req_valid  input  1  meaning requester presents a transfer.
REQ-006 Port req_ready  output  1  meaning initiator accepts a request this cycle.
REQ-007 Port req_write  input  1  meaning 1 = write, 0 = read.
REQ-008 Port req_addr  input  32  meaning byte address of transfer.
REQ-009 Port req_wdata  input  32  meaning write data.
REQ-010 Port rsp_valid / rsp_ready  output / input  1 / 1  meaning response handshake; rsp_ready is driven by the requester.
REQ-011 Port rsp_rdata / rsp_err  output / output  32 / 2  meaning read data; error code (00 ok, 01 out of window, 10 misaligned, 11 parity).
REQ-012 Port mem_address / mem_write_enable / mem_data_out  output / output / output  32 / 1 / 36  meaning SRAM2 bus; mem_data_out[35:32] are parity bits, [31:0] are data.
REQ-013 Port mem_data_in / mem_parity_error  input / input  32 / 1  meaning SRAM2 read data (valid between falling edge and next rising edge); SRAM2 parity error flag.

Function
REQ-014 Read data: mem_data_in SHALL be captured into a hold register on the falling edge of the ISSUE cycle; no other falling-edge logic.
REQ-015 FSM states: IDLE, ISSUE, RESP; encoding is free.
REQ-016 IDLE: req_ready=1; on req_valid, latch write, address and data; select the next state by the first matching rule of REQ-017 to REQ-019.
REQ-017 IDLE, address outside [BASE_ADDR, BASE_ADDR+WINDOW_BYTES-1] -> RESP with rsp_err=01; no bus activity.
REQ-018 IDLE, in window and addr[1:0]!=0 -> RESP with rsp_err=10; no bus activity.
REQ-019 IDLE, otherwise -> ISSUE.
REQ-020 ISSUE (exactly one cycle): mem_address = latched address; mem_write_enable = latched write; mem_data_out = {parity, wdata}; then -> RESP.
REQ-021 Outside ISSUE: mem_write_enable=0; mem_address=32'h0000_0000 (outside window, so SRAM2 stays idle); mem_data_out=0.
REQ-022 Parity generation: parity[i] = XOR of wdata[8i+7:8i] (even parity per byte, i=0..3).
REQ-023 In RESP, rsp_err SHALL be 11 if mem_parity_error was high during the write ISSUE cycle, else 00 for a bus access.
REQ-024 In RESP, rsp_rdata SHALL equal the falling-edge capture for reads and 0 for writes and error responses.
REQ-025 RESP: rsp_valid=1 with rsp_rdata and rsp_err held stable until rsp_ready=1; then -> IDLE.
REQ-026 req_ready SHALL be 0 in ISSUE and RESP; a request arriving then is not accepted.
REQ-027 Latency: request accepted in cycle 0 -> ISSUE in cycle 1 -> rsp_valid first asserted in cycle 2; error responses assert rsp_valid in cycle 1.
REQ-028 Window comparison SHALL be unsigned, 32-bit, with no overflow; the last word BASE_ADDR+WINDOW_BYTES-4 is legal.

Reset
REQ-029 reset_n low SHALL asynchronously force IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=00, mem_address=0, mem_write_enable=0, mem_data_out=0, and clear the hold register.
REQ-030 Reset during ISSUE or RESP SHALL abandon the transfer with no response.

Configuration
REQ-031 Macro SRAM2_PARITY_EN defined: parity per REQ-022 and parity error reporting per REQ-023.
REQ-032 Macro SRAM2_PARITY_EN undefined: mem_data_out[35:32]=4'b0000, mem_parity_error is ignored, and rsp_err=11 is never produced.

Verification
REQ-033 Write 0x1000_0010 data 0xA5A5_0F01 -> ISSUE cycle shows mem_write_enable=1 and mem_data_out=36'h0_A5A5_0F01 (parity 0000); rsp_err=00 in cycle 2.
REQ-034 Read 0x1000_0010 with bus model returning 0xDEAD_BEEF -> rsp_valid in cycle 2, rsp_rdata=0xDEAD_BEEF, rsp_err=00.
REQ-035 Read 0x1000_8000 and read 0x0FFF_FFFC -> rsp_err=01 in cycle 1, mem_write_enable never 1; read 0x1000_7FFC -> bus access, rsp_err=00.
REQ-036 Write 0x1000_0002 -> rsp_err=10 and no ISSUE; write data 0x0000_0001 with SRAM2_PARITY_EN -> parity 0001, and mem_parity_error forced high -> rsp_err=11.
REQ-037 Hold rsp_ready=0 for 5 cycles -> response stable and req_ready=0 throughout; reset_n pulsed low in ISSUE -> immediate IDLE, no rsp_valid.
